signed_range_gen: RTL and testbench
===================================

// Module: signed_range_gen
// PURPOSE
//   Hardware loop engine: accepts a signed (init, limit, step, dir) command and streams the index
//   sequence a Verilog for-loop would produce, using signed comparison throughout.
//   Supports both directions: dir=0 runs while idx <= limit, dir=1 runs while idx >= limit.
//   Sits between a command source and an index consumer; the consumer may apply backpressure.
// PARAMETERS
//   WIDTH   32   index/limit/step width; all treated as two's-complement signed
//   CNT_W   16   iteration counter width; hard cap = 2**CNT_W-1 iterations per command
// PORTS
//   clk          in   1       rising-edge clock
//   rst_n        in   1       asynchronous, active-low reset
//   start_valid  in   1       command valid
//   start_ready  out  1       command accepted when both high (high only in IDLE)
//   init_val     in   WIDTH   signed start index
//   limit        in   WIDTH   signed bound (inclusive)
//   step         in   WIDTH   signed increment, may be negative or zero
//   dir          in   1       0: continue while idx<=limit; 1: continue while idx>=limit
//   out_valid    out  1       index valid
//   out_ready    in   1       consumer accepts index
//   out_idx      out  WIDTH   current signed index
//   out_last     out  1       qualifies out_valid: final index of this command
//   done         out  1       one-cycle pulse when command completes
//   zero_trip    out  1       valid with done: no index was emitted
//   ovf          out  1       valid with done: terminated by signed overflow of idx+step
//   trunc        out  1       valid with done: terminated by CNT_W iteration cap
//   iter_count   out  CNT_W   indices emitted for current/last command; holds until next accept
// BEHAVIOUR
// - Reset (async, immediate): state=IDLE; start_ready=1; out_valid, out_last, done, zero_trip,
//   ovf, trunc=0; out_idx=0; iter_count=0. Reset mid-stream abandons the command, no done pulse.
// - States: IDLE -> EVAL -> (EMIT | DONE); EMIT -> EMIT | DONE; DONE -> IDLE.
// - IDLE: start_ready=1. Accept latches init/limit/step/dir, clears iter_count/flags -> EVAL.
//   start_valid outside IDLE is ignored (start_ready=0).
// - EVAL (1 cycle): cond = dir ? ($signed(idx) >= $signed(lim)) : ($signed(idx) <= $signed(lim)).
//   cond true -> EMIT; false -> DONE with zero_trip=1. Comparison never unsigned.
// - EMIT: out_valid=1, out_idx=idx. next = idx+step computed WIDTH+1 wide, signed.
//   out_last=1 if any of: next fails cond; signed overflow (sum bits [WIDTH:WIDTH-1] differ);
//   step==0; iter_count==2**CNT_W-2 (this emit reaches the cap).
//   On out_valid&out_ready: iter_count++; if out_last -> DONE (set ovf/trunc for the cause;
//   cond failure takes priority in flag reporting), else idx<=next, stay EMIT (1 index/cycle).
//   out_ready low: out_idx/out_last held stable, no state change.
// - step==0: exactly one index emitted (if cond true), out_last=1, no flag set.
// - Step sign opposing dir is legal; terminates by ovf or trunc.
// - DONE: done=1 for one cycle with zero_trip/ovf/trunc valid -> IDLE. Earliest next accept is
//   the cycle after DONE.
// - Latency: accept at cycle N -> first out_valid at N+2; zero-trip done at N+2.
// TESTING
// - init=2,limit=-1,step=1,dir=0 -> no out_valid; done at N+2, zero_trip=1, iter_count=0.
// - init=3,limit=-2,step=-1,dir=1 -> 3,2,1,0,-1,-2 back-to-back, out_last on -2, iter_count=6.
// - WIDTH=8: init=120,limit=127,step=5,dir=0 -> 120,125 (last), done with ovf=1.
// - init=0,limit=4,step=2,dir=0, out_ready toggling 1/0 -> 0,2,4 each held stable while stalled.
// - CNT_W=3: init=0,limit=100,step=1 -> 0..6 (7 indices), trunc=1; step=0 -> single index, last.
// - rst_n low during EMIT -> out_valid drops same instant, no done; next command runs cleanly.

Source files
------------

// File: rtl/signed_range_gen_if.sv
// Command and index-stream bundle for signed_range_gen.
// master: command source plus index consumer; slave: the loop engine itself.
interface signed_range_gen_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] init_val;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] step;
  logic             dir;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_idx;
  logic             out_last;
  logic             done;
  logic             zero_trip;
  logic             ovf;
  logic             trunc;
  logic [CNT_W-1:0] iter_count;

  modport master (
    output start_valid, init_val, limit, step, dir, out_ready,
    input  start_ready, out_valid, out_idx, out_last, done, zero_trip, ovf, trunc, iter_count
  );

  modport slave (
    input  start_valid, init_val, limit, step, dir, out_ready,
    output start_ready, out_valid, out_idx, out_last, done, zero_trip, ovf, trunc, iter_count
  );
endinterface

// File: rtl/signed_range_gen.sv
// Signed hardware for-loop engine: streams init, init+step, ... while the signed bound holds,
// terminating early on signed overflow, zero step or the iteration cap.
module signed_range_gen #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               rst_n,
  signed_range_gen_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // An emit taken at this count brings the total to the 2**CNT_W-1 cap.
  localparam logic [CNT_W-1:0] CNT_LAST_EMIT = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0] CNT_ONE       = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic cond_ok(input logic [WIDTH-1:0] v, input logic [WIDTH-1:0] lim,
                                   input logic d);
    logic r;
    if (d) r = ($signed(v) >= $signed(lim));
    else   r = ($signed(v) <= $signed(lim));
    return r;
  endfunction

  // {last, ovf, trunc} for emitting v after cnt indices; a failing bound masks the other causes.
  function automatic logic [2:0] emit_status(input logic [WIDTH-1:0] v, input logic [WIDTH-1:0] lim,
                                             input logic [WIDTH-1:0] stp, input logic d,
                                             input logic [CNT_W-1:0] cnt);
    logic [WIDTH:0] sum;
    logic [2:0]     r;
    sum = {v[WIDTH-1], v} + {stp[WIDTH-1], stp};
    if (!cond_ok(sum[WIDTH-1:0], lim, d))    r = 3'b100;
    else if (sum[WIDTH] != sum[WIDTH-1])     r = 3'b110;
    else if (stp == {WIDTH{1'b0}})           r = 3'b100;
    else if (cnt == CNT_LAST_EMIT)           r = 3'b101;
    else                                     r = 3'b000;
    return r;
  endfunction

  state_t           state_r, state_s;
  logic [WIDTH-1:0] idx_r, idx_s, lim_r, lim_s, step_r, step_s, nxt_s;
  logic             dir_r, dir_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             start_ready_r, start_ready_s, out_valid_r, out_valid_s, out_last_r, out_last_s;
  logic             done_r, done_s, zero_trip_r, zero_trip_s, ovf_r, ovf_s, trunc_r, trunc_s;
  logic             cause_ovf_r, cause_ovf_s, cause_trunc_r, cause_trunc_s;
  logic [2:0]       cur_st_s, adv_st_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // Datapath and registered outputs; a reset abandons the command without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r         <= {WIDTH{1'b0}};
      lim_r         <= {WIDTH{1'b0}};
      step_r        <= {WIDTH{1'b0}};
      dir_r         <= 1'b0;
      cnt_r         <= {CNT_W{1'b0}};
      start_ready_r <= 1'b1;
      out_valid_r   <= 1'b0;
      out_last_r    <= 1'b0;
      done_r        <= 1'b0;
      zero_trip_r   <= 1'b0;
      ovf_r         <= 1'b0;
      trunc_r       <= 1'b0;
      cause_ovf_r   <= 1'b0;
      cause_trunc_r <= 1'b0;
    end else begin
      idx_r         <= idx_s;
      lim_r         <= lim_s;
      step_r        <= step_s;
      dir_r         <= dir_s;
      cnt_r         <= cnt_s;
      start_ready_r <= start_ready_s;
      out_valid_r   <= out_valid_s;
      out_last_r    <= out_last_s;
      done_r        <= done_s;
      zero_trip_r   <= zero_trip_s;
      ovf_r         <= ovf_s;
      trunc_r       <= trunc_s;
      cause_ovf_r   <= cause_ovf_s;
      cause_trunc_r <= cause_trunc_s;
    end
  end

  // Next-state and next-output decode; out_last is precomputed for the index about to be shown.
  always_comb begin
    state_s       = state_r;
    idx_s         = idx_r;
    lim_s         = lim_r;
    step_s        = step_r;
    dir_s         = dir_r;
    cnt_s         = cnt_r;
    start_ready_s = start_ready_r;
    out_valid_s   = out_valid_r;
    out_last_s    = out_last_r;
    done_s        = 1'b0;
    zero_trip_s   = zero_trip_r;
    ovf_s         = ovf_r;
    trunc_s       = trunc_r;
    cause_ovf_s   = cause_ovf_r;
    cause_trunc_s = cause_trunc_r;
    nxt_s         = idx_r + step_r;
    cur_st_s      = emit_status(idx_r, lim_r, step_r, dir_r, cnt_r);
    adv_st_s      = emit_status(nxt_s, lim_r, step_r, dir_r, cnt_r + CNT_ONE);

    case (state_r)
      ST_IDLE: begin
        if (bus.start_valid && start_ready_r) begin
          state_s       = ST_EVAL;
          idx_s         = bus.init_val;
          lim_s         = bus.limit;
          step_s        = bus.step;
          dir_s         = bus.dir;
          cnt_s         = {CNT_W{1'b0}};
          zero_trip_s   = 1'b0;
          ovf_s         = 1'b0;
          trunc_s       = 1'b0;
          start_ready_s = 1'b0;
        end else begin
          start_ready_s = 1'b1;
        end
      end
      ST_EVAL: begin
        if (cond_ok(idx_r, lim_r, dir_r)) begin
          state_s       = ST_EMIT;
          out_valid_s   = 1'b1;
          out_last_s    = cur_st_s[2];
          cause_ovf_s   = cur_st_s[1];
          cause_trunc_s = cur_st_s[0];
        end else begin
          state_s     = ST_DONE;
          done_s      = 1'b1;
          zero_trip_s = 1'b1;
        end
      end
      ST_EMIT: begin
        if (bus.out_ready) begin
          cnt_s = cnt_r + CNT_ONE;
          if (out_last_r) begin
            state_s     = ST_DONE;
            out_valid_s = 1'b0;
            out_last_s  = 1'b0;
            done_s      = 1'b1;
            ovf_s       = cause_ovf_r;
            trunc_s     = cause_trunc_r;
          end else begin
            idx_s         = nxt_s;
            out_last_s    = adv_st_s[2];
            cause_ovf_s   = adv_st_s[1];
            cause_trunc_s = adv_st_s[0];
          end
        end else begin
          state_s = ST_EMIT;
        end
      end
      ST_DONE: begin
        state_s       = ST_IDLE;
        start_ready_s = 1'b1;
      end
      default: begin
        state_s       = ST_IDLE;
        start_ready_s = 1'b1;
        out_valid_s   = 1'b0;
        out_last_s    = 1'b0;
      end
    endcase
  end

  assign bus.start_ready = start_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_idx     = idx_r;
  assign bus.out_last    = out_last_r;
  assign bus.done        = done_r;
  assign bus.zero_trip   = zero_trip_r;
  assign bus.ovf         = ovf_r;
  assign bus.trunc       = trunc_r;
  assign bus.iter_count  = cnt_r;

endmodule

// File: tb/tb_signed_range_gen.sv
// Self-checking bench for signed_range_gen (WIDTH=8, CNT_W=3) against a loop-level reference model.
module tb_signed_range_gen;
  localparam int WIDTH = 8;
  localparam int CNT_W = 3;
  localparam int CAP   = (1 << CNT_W) - 1;
  localparam int MAXV  = (1 << (WIDTH - 1)) - 1;
  localparam int MINV  = -(1 << (WIDTH - 1));

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  int exp_q[$];
  bit exp_zt, exp_ovf, exp_tr;

  signed_range_gen_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  signed_range_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic bit holds(int v, int lim, bit d);
    return d ? (v >= lim) : (v <= lim);
  endfunction

  function automatic int wrap(int n);
    logic signed [WIDTH-1:0] b;
    b = WIDTH'(n);
    return int'(b);
  endfunction

  // Reference: the index list of a for-loop in WIDTH-bit signed arithmetic, with the cap applied.
  task automatic model(input int init, input int lim, input int stp, input bit d);
    int v, n;
    exp_q.delete();
    exp_zt = 0; exp_ovf = 0; exp_tr = 0;
    v = init;
    if (!holds(v, lim, d)) exp_zt = 1;
    else begin
      for (int it = 0; it < 1000; it++) begin
        exp_q.push_back(v);
        n = v + stp;
        if (!holds(wrap(n), lim, d)) break;
        if (n > MAXV || n < MINV) begin exp_ovf = 1; break; end
        if (stp == 0) break;
        if (exp_q.size() == CAP) begin exp_tr = 1; break; end
        v = n;
      end
    end
  endtask

  // rmode: 0 always ready, 1 toggling, 2 random. noisy keeps start_valid high while busy.
  task automatic run_cmd(input string name, input int init, input int lim, input int stp,
                         input bit d, input int rmode, input bit noisy);
    int n, k, waitc;
    bit seen_end, r;
    logic [WIDTH-1:0] e_idx;
    model(init, lim, stp, d);
    n = exp_q.size();
    waitc = 0;
    @(negedge clk);
    while (bus.start_ready !== 1'b1 && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    checks++;
    if (bus.start_ready !== 1'b1) begin
      errors++; $display("FAIL %s start_ready actual=%b expected=1", name, bus.start_ready);
    end
    bus.start_valid = 1'b1;
    bus.init_val    = WIDTH'(init);
    bus.limit       = WIDTH'(lim);
    bus.step        = WIDTH'(stp);
    bus.dir         = d;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.done !== 1'b0 || bus.start_ready !== 1'b0 ||
        bus.iter_count !== {CNT_W{1'b0}}) begin
      errors++;
      $display("FAIL %s eval_cycle actual valid=%b done=%b ready=%b cnt=%0d expected 0 0 0 0",
               name, bus.out_valid, bus.done, bus.start_ready, bus.iter_count);
    end
    bus.start_valid = noisy;
    if (noisy) begin
      bus.init_val = WIDTH'($urandom);
      bus.limit    = WIDTH'($urandom);
      bus.step     = WIDTH'($urandom);
    end
    k = 0;
    seen_end = 0;
    for (int cyc = 0; cyc < 200 && !seen_end; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        checks++;
        if (bus.out_valid !== (n > 0) || bus.done !== (n == 0)) begin
          errors++;
          $display("FAIL %s latency actual valid=%b done=%b expected valid=%b done=%b",
                   name, bus.out_valid, bus.done, n > 0, n == 0);
        end
      end
      if (bus.done === 1'b1) begin
        seen_end = 1;
        bus.start_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || k != n || bus.iter_count !== CNT_W'(n)) begin
          errors++;
          $display("FAIL %s done_count actual valid=%b taken=%0d cnt=%0d expected valid=0 count=%0d",
                   name, bus.out_valid, k, bus.iter_count, n);
        end
        checks++;
        if (bus.zero_trip !== exp_zt || bus.ovf !== exp_ovf || bus.trunc !== exp_tr) begin
          errors++;
          $display("FAIL %s flags actual zt=%b ovf=%b trunc=%b expected zt=%b ovf=%b trunc=%b",
                   name, bus.zero_trip, bus.ovf, bus.trunc, exp_zt, exp_ovf, exp_tr);
        end
      end else if (bus.out_valid === 1'b1) begin
        checks++;
        if (k >= n) begin
          errors++;
          $display("FAIL %s extra_index actual=%0d expected none (k=%0d)", name,
                   $signed(bus.out_idx), k);
        end else begin
          e_idx = WIDTH'(exp_q[k]);
          if (bus.out_idx !== e_idx || bus.out_last !== logic'(k == n - 1)) begin
            errors++;
            $display("FAIL %s index k=%0d actual=%0d last=%b expected=%0d last=%b", name, k,
                     $signed(bus.out_idx), bus.out_last, $signed(e_idx), k == n - 1);
          end
        end
        case (rmode)
          0:       r = 1'b1;
          1:       r = (cyc % 2 == 0);
          default: r = 1'($urandom_range(1));
        endcase
        bus.out_ready = r;
        if (r) k++;
      end else begin
        checks++; errors++;
        $display("FAIL %s idle_gap actual valid=0 done=0 expected valid or done (k=%0d)", name, k);
      end
    end
    if (!seen_end) begin
      checks++; errors++;
      $display("FAIL %s timeout actual no done expected done after %0d indices", name, n);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.start_ready !== 1'b1 || bus.iter_count !== CNT_W'(n)) begin
      errors++;
      $display("FAIL %s post_done actual done=%b ready=%b cnt=%0d expected 0 1 %0d",
               name, bus.done, bus.start_ready, bus.iter_count, n);
    end
  endtask

  task automatic test_reset();
    bus.start_valid = 1'b0; bus.init_val = '0; bus.limit = '0; bus.step = '0;
    bus.dir = 1'b0; bus.out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #20;
    checks++;
    if (bus.start_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 ||
        bus.done !== 1'b0 || bus.zero_trip !== 1'b0 || bus.ovf !== 1'b0 || bus.trunc !== 1'b0 ||
        bus.out_idx !== {WIDTH{1'b0}} || bus.iter_count !== {CNT_W{1'b0}}) begin
      errors++;
      $display("FAIL reset actual ready=%b valid=%b last=%b done=%b zt=%b ovf=%b tr=%b idx=%0d cnt=%0d expected 1 0 0 0 0 0 0 0 0",
               bus.start_ready, bus.out_valid, bus.out_last, bus.done, bus.zero_trip, bus.ovf,
               bus.trunc, bus.out_idx, bus.iter_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_stream();
    int done_seen;
    @(negedge clk);
    bus.start_valid = 1'b1; bus.init_val = WIDTH'(0); bus.limit = WIDTH'(100);
    bus.step = WIDTH'(1); bus.dir = 1'b0;
    @(negedge clk);
    bus.start_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL mid_reset streaming actual valid=%b expected=1", bus.out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.done !== 1'b0 || bus.start_ready !== 1'b1 ||
        bus.iter_count !== {CNT_W{1'b0}}) begin
      errors++;
      $display("FAIL mid_reset immediate actual valid=%b done=%b ready=%b cnt=%0d expected 0 0 1 0",
               bus.out_valid, bus.done, bus.start_ready, bus.iter_count);
    end
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_seen++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      errors++; $display("FAIL mid_reset no_done actual=%0d expected=0", done_seen);
    end
    run_cmd("after_reset", -4, 2, 3, 1'b0, 0, 1'b0);
  endtask

  task automatic test_zero_trip();
    run_cmd("zero_trip", 2, -1, 1, 1'b0, 0, 1'b0);
    run_cmd("zero_trip_down", -7, -6, -1, 1'b1, 0, 1'b0);
  endtask

  task automatic test_count_down();
    run_cmd("count_down", 3, -2, -1, 1'b1, 0, 1'b0);
  endtask

  task automatic test_signed_compare();
    run_cmd("signed_cmp", -5, 3, 2, 1'b0, 0, 1'b0);
  endtask

  task automatic test_overflow();
    run_cmd("overflow", 120, 127, 5, 1'b0, 0, 1'b0);
    run_cmd("wrap_fails_bound", -125, 0, -2, 1'b0, 0, 1'b0);
    run_cmd("overflow_down", -120, -128, -5, 1'b1, 2, 1'b0);
  endtask

  task automatic test_backpressure();
    run_cmd("backpressure", 0, 4, 2, 1'b0, 1, 1'b0);
  endtask

  task automatic test_cap_and_zero_step();
    run_cmd("trunc", 0, 100, 1, 1'b0, 0, 1'b0);
    run_cmd("zero_step", 5, 100, 0, 1'b0, 0, 1'b0);
    run_cmd("zero_step_down", -3, -10, 0, 1'b1, 1, 1'b0);
    run_cmd("opposing", 0, 10, -1, 1'b0, 2, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_cmd("b2b_a", 10, 13, 1, 1'b0, 0, 1'b1);
    run_cmd("b2b_b", 10, 4, -3, 1'b1, 0, 1'b1);
  endtask

  task automatic test_random();
    int init, lim, stp;
    for (int i = 0; i < 25; i++) begin
      init = int'($urandom_range(255)) - 128;
      lim  = int'($urandom_range(255)) - 128;
      if ($urandom_range(3) == 0) stp = int'($urandom_range(255)) - 128;
      else                        stp = int'($urandom_range(16)) - 8;
      run_cmd("random", init, lim, stp, 1'($urandom_range(1)), int'($urandom_range(2)),
              1'($urandom_range(1)));
    end
  endtask

  initial begin
    test_reset();
    test_zero_trip();
    test_count_down();
    test_signed_compare();
    test_overflow();
    test_backpressure();
    test_cap_and_zero_step();
    test_back_to_back();
    test_random();
    test_reset_mid_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
